// File: rtl/ex_bundle_issue_seq_if.sv
// Bundle/execute handshake between ID, the issue sequencer and the 5-lane execute stage.
// Slot k of a bundle always maps to execute lane k+1.
interface ex_bundle_issue_seq_if #(
    parameter int unsigned CNT_W = 16
);
    logic               bndValid;
    logic               bndReady;
    logic [4:0]         bndMask;
    logic [104:0]       bndSrcIds;
    logic [34:0]        bndDstIds;
    logic [4:0]         bndMemOp;
    logic [4:0]         exLaneEn;
    logic               exGroupLast;
    logic [1:0]         exOK;
    logic               exFault;
    logic               flush;
    logic [CNT_W-1:0]   cntSplit;
    logic [CNT_W-1:0]   cntHold;

    modport master (
        output bndValid, bndMask, bndSrcIds, bndDstIds, bndMemOp, exOK, flush,
        input  bndReady, exLaneEn, exGroupLast, exFault, cntSplit, cntHold
    );

    modport slave (
        input  bndValid, bndMask, bndSrcIds, bndDstIds, bndMemOp, exOK, flush,
        output bndReady, exLaneEn, exGroupLast, exFault, cntSplit, cntHold
    );
endinterface

// File: rtl/ex_bundle_issue_seq.sv
// Issue sequencer: splits a decoded 5-slot bundle into hazard-free in-order groups
// for the combined execute stage, repeating on HOLD and aborting on FAULT.
module ex_bundle_issue_seq #(
    parameter logic [6:0]  REG_NONE = 7'h7F,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    ex_bundle_issue_seq_if.slave   bus
);
    localparam int unsigned SLOTS  = 5;
    localparam int unsigned ID_W   = 7;
    localparam int unsigned SRC_W  = 3 * ID_W;

    localparam logic [1:0] EX_OK   = 2'd0;
    localparam logic [1:0] EX_HOLD = 2'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        FAULTED = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [SLOTS-1:0]         pending_q, pending_d;
    logic [SLOTS*SRC_W-1:0]   src_q, src_d;
    logic [SLOTS*ID_W-1:0]    dst_q, dst_d;
    logic [1:0]               groups_q, groups_d;
    logic                     fault_q, fault_d;
    logic [CNT_W-1:0]         cnt_split_q, cnt_split_d;
    logic [CNT_W-1:0]         cnt_hold_q, cnt_hold_d;

    logic [SLOTS-1:0]         group;
    logic                     group_last;
    logic                     illegal;

    // Group = longest in-order prefix of pending slots free of RAW/WAW against earlier members
    always_comb begin
        logic open;
        logic started;
        logic hazard;
        logic [ID_W-1:0] wr;
        group   = '0;
        open    = 1'b1;
        started = 1'b0;
        for (int k = 0; k < int'(SLOTS); k++) begin
            hazard = 1'b0;
            for (int m = 0; m < int'(SLOTS); m++) begin
                wr = dst_q[ID_W*m +: ID_W];
                if (m < k && group[m] && wr != REG_NONE &&
                    (wr == src_q[SRC_W*k + 2*ID_W +: ID_W] ||
                     wr == src_q[SRC_W*k + ID_W +: ID_W] ||
                     wr == src_q[SRC_W*k +: ID_W] ||
                     wr == dst_q[ID_W*k +: ID_W]))
                    hazard = 1'b1;
            end
            if (pending_q[k] && open) begin
                if (started && hazard) begin
                    open = 1'b0;
                end else begin
                    group[k] = 1'b1;
                    started  = 1'b1;
                end
            end
        end
    end

    assign group_last = ((pending_q & ~group) == '0);
    // Only lane 1 owns the memory/control-register port
    assign illegal    = |(bus.bndMemOp & bus.bndMask & 5'b11110);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        src_d       = src_q;
        dst_d       = dst_q;
        groups_d    = groups_q;
        fault_d     = 1'b0;
        cnt_split_d = cnt_split_q;
        cnt_hold_d  = cnt_hold_q;

        if (bus.flush) begin
            pending_d = '0;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.bndValid) begin
                        src_d    = bus.bndSrcIds;
                        dst_d    = bus.bndDstIds;
                        groups_d = 2'd0;
                        if (illegal) begin
                            pending_d = '0;
                            fault_d   = 1'b1;
                            state_d   = FAULTED;
                        end else begin
                            pending_d = bus.bndMask;
                            if (bus.bndMask != '0)
                                state_d = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.exOK == EX_OK) begin
                        pending_d = pending_q & ~group;
                        if (groups_q != 2'd2)
                            groups_d = groups_q + 2'd1;
                        if (groups_q == 2'd1 && cnt_split_q != '1)
                            cnt_split_d = cnt_split_q + CNT_W'(1);
                        if (group_last)
                            state_d = IDLE;
                    end else if (bus.exOK == EX_HOLD) begin
                        if (cnt_hold_q != '1)
                            cnt_hold_d = cnt_hold_q + CNT_W'(1);
                    end else begin
                        pending_d = '0;
                        fault_d   = 1'b1;
                        state_d   = FAULTED;
                    end
                end
                FAULTED: ;
                default: begin
                    pending_d = '0;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            groups_q    <= 2'd0;
            fault_q     <= 1'b0;
            cnt_split_q <= '0;
            cnt_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            groups_q    <= groups_d;
            fault_q     <= fault_d;
            cnt_split_q <= cnt_split_d;
            cnt_hold_q  <= cnt_hold_d;
        end
    end

    // Lane enables follow registered state only, so reset drops them immediately
    assign bus.bndReady    = (state_q == IDLE);
    assign bus.exLaneEn    = (state_q == ISSUE) ? group : '0;
    assign bus.exGroupLast = (state_q == ISSUE) && group_last;
    assign bus.exFault     = fault_q;
    assign bus.cntSplit    = cnt_split_q;
    assign bus.cntHold     = cnt_hold_q;
endmodule

// File: tb/tb_ex_bundle_issue_seq.sv
// Self-checking bench for ex_bundle_issue_seq: directed scenarios plus random bundles
// checked against a write-set reference model of the grouping rules.
module tb_ex_bundle_issue_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ex_bundle_issue_seq_if bus_if ();

    ex_bundle_issue_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_split = 0;
    int exp_hold  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: walk pending slots in order, track registers written so far, stop at first conflict
    function automatic logic [4:0] model_group(input logic [4:0] pend, input logic [104:0] src,
                                               input logic [34:0] dst);
        logic [6:0] writes[$];
        logic [4:0] g;
        logic [6:0] rd[4];
        g = '0;
        for (int k = 0; k < 5; k++) begin
            if (!pend[k]) continue;
            rd[0] = src[21*k+14 +: 7];
            rd[1] = src[21*k+7 +: 7];
            rd[2] = src[21*k +: 7];
            rd[3] = dst[7*k +: 7];
            foreach (writes[i])
                for (int r = 0; r < 4; r++)
                    if (writes[i] == rd[r]) return g;
            g[k] = 1'b1;
            if (dst[7*k +: 7] != 7'h7F) writes.push_back(dst[7*k +: 7]);
        end
        return g;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 32'(bus_if.bndReady), 32'd1);
        chk({tag, "_lane"}, 32'(bus_if.exLaneEn), 32'd0);
        chk({tag, "_split"}, 32'(bus_if.cntSplit), 32'(exp_split));
        chk({tag, "_hold"}, 32'(bus_if.cntHold), 32'(exp_hold));
    endtask

    // Called at a negedge with the sequencer idle; returns at a negedge with it idle again
    task automatic run_bundle(input logic [4:0] mask, input logic [104:0] src, input logic [34:0] dst,
                              input logic [4:0] memop, input int holds_first, input int fault_grp,
                              input bit rand_hold);
        logic [4:0] pend, g;
        int gdone, holds, iter;
        chk("accept_ready", 32'(bus_if.bndReady), 32'd1);
        bus_if.bndValid  = 1'b1;
        bus_if.bndMask   = mask;
        bus_if.bndSrcIds = src;
        bus_if.bndDstIds = dst;
        bus_if.bndMemOp  = memop;
        bus_if.exOK      = 2'd2;
        @(negedge clock);
        bus_if.bndValid = 1'b0;
        bus_if.bndMask  = 5'($urandom);
        if (|(memop & mask & 5'b11110)) begin
            chk("illegal_lane", 32'(bus_if.exLaneEn), 32'd0);
            chk("illegal_fault", 32'(bus_if.exFault), 32'd1);
            chk("illegal_ready", 32'(bus_if.bndReady), 32'd0);
            @(negedge clock);
            chk("faulted_pulse", 32'(bus_if.exFault), 32'd0);
            chk("faulted_lane", 32'(bus_if.exLaneEn), 32'd0);
            chk("faulted_ready", 32'(bus_if.bndReady), 32'd0);
            bus_if.flush = 1'b1;
            @(negedge clock);
            bus_if.flush = 1'b0;
            check_idle("after_flush");
            return;
        end
        if (mask == 5'd0) begin
            check_idle("empty");
            return;
        end
        pend = mask; gdone = 0; holds = 0; iter = 0;
        while (pend != 5'd0) begin
            iter++;
            if (iter > 200) begin
                chk("loop_bound", 32'd0, 32'd1);
                return;
            end
            g = model_group(pend, src, dst);
            chk("lane", 32'(bus_if.exLaneEn), 32'(g));
            chk("last", 32'(bus_if.exGroupLast), 32'((pend & ~g) == 5'd0));
            chk("busy_ready", 32'(bus_if.bndReady), 32'd0);
            chk("no_fault", 32'(bus_if.exFault), 32'd0);
            if (gdone == fault_grp) begin
                bus_if.exOK = 2'($urandom_range(2, 3));
                @(negedge clock);
                bus_if.exOK = 2'd0;
                chk("abort_fault", 32'(bus_if.exFault), 32'd1);
                chk("abort_lane", 32'(bus_if.exLaneEn), 32'd0);
                chk("abort_ready", 32'(bus_if.bndReady), 32'd0);
                @(negedge clock);
                chk("abort_pulse", 32'(bus_if.exFault), 32'd0);
                chk("abort_lane2", 32'(bus_if.exLaneEn), 32'd0);
                bus_if.flush = 1'b1;
                @(negedge clock);
                bus_if.flush = 1'b0;
                check_idle("abort_flush");
                return;
            end
            if ((gdone == 0 && holds < holds_first) || (rand_hold && $urandom_range(3) == 0)) begin
                bus_if.exOK = 2'd1;
                holds++;
                exp_hold++;
            end else begin
                bus_if.exOK = 2'd0;
                pend &= ~g;
                gdone++;
                if (gdone == 2) exp_split++;
            end
            @(negedge clock);
        end
        bus_if.exOK = 2'd2;
        check_idle("done");
    endtask

    function automatic logic [104:0] indep_src();
        logic [104:0] s;
        for (int k = 0; k < 5; k++)
            s[21*k +: 21] = {7'(10 + 3*k), 7'(11 + 3*k), 7'(12 + 3*k)};
        return s;
    endfunction

    function automatic logic [6:0] rid();
        return ($urandom_range(7) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
    endfunction

    logic [104:0] src;
    logic [34:0]  dst;

    initial begin
        bus_if.bndValid = 1'b0; bus_if.bndMask = '0; bus_if.bndSrcIds = '0;
        bus_if.bndDstIds = '0;  bus_if.bndMemOp = '0; bus_if.exOK = 2'd2; bus_if.flush = 1'b0;

        #12;
        chk("rst_ready", 32'(bus_if.bndReady), 32'd1);
        chk("rst_lane", 32'(bus_if.exLaneEn), 32'd0);
        chk("rst_fault", 32'(bus_if.exFault), 32'd0);
        chk("rst_last", 32'(bus_if.exGroupLast), 32'd0);
        chk("rst_split", 32'(bus_if.cntSplit), 32'd0);
        chk("rst_hold", 32'(bus_if.cntHold), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Independent full bundle issues as one group
        src = indep_src();
        dst = {7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
        run_bundle(5'b11111, src, dst, 5'b00001, 0, -1, 1'b0);

        // RAW: slot2 reads slot0's destination
        dst = {7'd5, 7'd4, 7'd7, 7'd2, 7'd3};
        src[21*2+14 +: 7] = 7'd3;
        run_bundle(5'b11111, src, dst, 5'b00000, 0, -1, 1'b0);

        // WAW between slots 1 and 3
        src = indep_src();
        dst = {7'd5, 7'd8, 7'd3, 7'd8, 7'd1};
        run_bundle(5'b01010, src, dst, 5'b00000, 0, -1, 1'b0);

        // Three HOLD cycles on one group
        dst = {7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
        run_bundle(5'b00111, src, dst, 5'b00000, 3, -1, 1'b0);

        // Memory op on lane 3 is illegal
        run_bundle(5'b00111, src, dst, 5'b00100, 0, -1, 1'b0);

        // Empty bundle consumed silently
        run_bundle(5'b00000, src, dst, 5'b00000, 0, -1, 1'b0);

        // FAULT on the first of two groups
        dst = {7'd5, 7'd4, 7'd7, 7'd2, 7'd3};
        src[21*2+14 +: 7] = 7'd3;
        run_bundle(5'b11111, src, dst, 5'b00000, 0, 0, 1'b0);

        // flush beats bndValid in IDLE
        bus_if.bndValid = 1'b1; bus_if.bndMask = 5'b00001; bus_if.flush = 1'b1;
        @(negedge clock);
        bus_if.bndValid = 1'b0; bus_if.flush = 1'b0;
        check_idle("flush_prio");

        // Random bundles with hazards, holds, faults and illegal mem ops
        for (int n = 0; n < 60; n++) begin
            logic [4:0] mask, memop;
            for (int k = 0; k < 5; k++) begin
                src[21*k +: 21] = {rid(), rid(), rid()};
                dst[7*k +: 7]   = rid();
            end
            mask  = 5'($urandom);
            memop = {($urandom_range(5) == 0) ? 4'($urandom) : 4'd0, 1'($urandom)};
            run_bundle(mask, src, dst, memop, 0,
                       ($urandom_range(9) == 0) ? int'($urandom_range(0, 1)) : -1, 1'b1);
        end

        // Reset in the middle of ISSUE clears outputs immediately
        src = indep_src();
        dst = {7'd5, 7'd4, 7'd7, 7'd2, 7'd3};
        src[21*2+14 +: 7] = 7'd3;
        bus_if.bndValid = 1'b1; bus_if.bndMask = 5'b11111;
        bus_if.bndSrcIds = src; bus_if.bndDstIds = dst; bus_if.bndMemOp = 5'b0;
        @(negedge clock);
        bus_if.bndValid = 1'b0;
        chk("pre_rst_lane", 32'(bus_if.exLaneEn), 32'(5'b00011));
        reset = 1'b1;
        #1;
        chk("mid_rst_lane", 32'(bus_if.exLaneEn), 32'd0);
        chk("mid_rst_ready", 32'(bus_if.bndReady), 32'd1);
        chk("mid_rst_split", 32'(bus_if.cntSplit), 32'd0);
        chk("mid_rst_hold", 32'(bus_if.cntHold), 32'd0);
        exp_split = 0; exp_hold = 0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_idle("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
